column_1_normalize: RTL and testbench

//   Consumer of the column-1 amplitude interface (amplitude + valid). Takes a11, a21 and
//   the 17-bit amplitude, produces unit-vector terms cos = a11/amp, sin = a21/amp in signed

---
 rtl/column_1_normalize.sv | 132 +++++++++++++
 tb/tb_column_1_normalize.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/column_1_normalize.sv
// Column-1 normalizer: cos = a11/amp, sin = a21/amp via two parallel restoring dividers.
// Optional `NORM_ROUND_EN adds a guard iteration and rounds half up instead of truncating.
module column_1_normalize #(
  parameter int FRAC_W = 14
) (
  input  logic                     I_sys_clk,
  input  logic                     I_sys_rstn,
  input  logic                     I_amp_valid,
  input  logic [16:0]              I_column_1_amp,
  input  logic [15:0]              I_a11,
  input  logic [15:0]              I_a21,
  output logic signed [FRAC_W+1:0] O_cos,
  output logic signed [FRAC_W+1:0] O_sin,
  output logic                     O_norm_valid,
  output logic                     O_div_zero,
  output logic                     O_busy
);

`ifdef NORM_ROUND_EN
  localparam int NITER = FRAC_W + 2;
`else
  localparam int NITER = FRAC_W + 1;
`endif
  localparam int OUT_W = FRAC_W + 2;
  localparam int REM_W = 18;
  localparam int CW    = $clog2(NITER);
  localparam logic [CW-1:0]  LAST_CNT = CW'(NITER - 1);
  localparam logic [NITER:0] ONE      = (NITER + 1)'(1) << FRAC_W;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SIGN} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [16:0]        amp_q;
  logic [REM_W-1:0]   rem_x_q, rem_y_q;
  logic [REM_W-1:0]   rem_x_d, rem_y_d;
  logic [NITER-1:0]   q_x_q, q_y_q;
  logic               bit_x_d, bit_y_d;
  logic               neg_x_q, neg_y_q, zero_q;

  // |a| of a 16-bit two's-complement value; -32768 becomes 32768 in 17 bits.
  function automatic logic [16:0] mag17(input logic [15:0] a);
    return a[15] ? (17'd0 - {1'b1, a}) : {1'b0, a};
  endfunction

  // One restoring step: iteration 0 compares the unshifted remainder (integer bit).
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] rem,
                                               input logic [16:0]      amp,
                                               input logic             first);
    logic [REM_W-1:0] sh;
    sh = first ? rem : (rem << 1);
    if (sh >= {1'b0, amp}) return {sh - {1'b0, amp}, 1'b1};
    else                   return {sh, 1'b0};
  endfunction

  function automatic logic signed [OUT_W-1:0] finish_term(input logic [NITER-1:0] q,
                                                          input logic             neg);
    logic [NITER:0] m;
`ifdef NORM_ROUND_EN
    m = ({1'b0, q} + (NITER + 1)'(1)) >> 1;
`else
    m = {1'b0, q};
`endif
    // Any quotient with the integer bit set means |a| >= amp, so the clamp covers it.
    if (m > ONE) m = ONE;
    return neg ? (OUT_W'(0) - m[OUT_W-1:0]) : m[OUT_W-1:0];
  endfunction

  always_comb begin
    {rem_x_d, bit_x_d} = div_step(rem_x_q, amp_q, cnt_q == '0);
    {rem_y_d, bit_y_d} = div_step(rem_y_q, amp_q, cnt_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      amp_q        <= '0;
      rem_x_q      <= '0;
      rem_y_q      <= '0;
      q_x_q        <= '0;
      q_y_q        <= '0;
      neg_x_q      <= 1'b0;
      neg_y_q      <= 1'b0;
      zero_q       <= 1'b0;
      O_cos        <= '0;
      O_sin        <= '0;
      O_norm_valid <= 1'b0;
      O_div_zero   <= 1'b0;
      O_busy       <= 1'b0;
    end else begin
      O_norm_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (I_amp_valid) begin
            rem_x_q <= {1'b0, mag17(I_a11)};
            rem_y_q <= {1'b0, mag17(I_a21)};
            neg_x_q <= I_a11[15];
            neg_y_q <= I_a21[15];
            amp_q   <= I_column_1_amp;
            zero_q  <= (I_column_1_amp == 17'd0);
            q_x_q   <= '0;
            q_y_q   <= '0;
            cnt_q   <= '0;
            O_busy  <= 1'b1;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          rem_x_q <= rem_x_d;
          rem_y_q <= rem_y_d;
          q_x_q   <= {q_x_q[NITER-2:0], bit_x_d};
          q_y_q   <= {q_y_q[NITER-2:0], bit_y_d};
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) state_q <= S_SIGN;
        end
        S_SIGN: begin
          O_cos        <= zero_q ? '0 : finish_term(q_x_q, neg_x_q);
          O_sin        <= zero_q ? '0 : finish_term(q_y_q, neg_y_q);
          O_div_zero   <= zero_q;
          O_norm_valid <= 1'b1;
          O_busy       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_1_normalize.sv
// Scoreboard bench for column_1_normalize: expected results queued at strobe, checked at pulse.
module tb_column_1_normalize;
  localparam int FRAC_W = 14;
  localparam int OUT_W  = FRAC_W + 2;
`ifdef NORM_ROUND_EN
  localparam int LAT = FRAC_W + 3;
`else
  localparam int LAT = FRAC_W + 2;
`endif

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    amp_valid = 1'b0;
  logic [16:0]             amp_i = '0;
  logic [15:0]             a11_i = '0, a21_i = '0;
  logic signed [OUT_W-1:0] cos_o, sin_o;
  logic                    norm_valid_o, div_zero_o, busy_o;

  column_1_normalize #(.FRAC_W(FRAC_W)) dut (
    .I_sys_clk(clk), .I_sys_rstn(rstn), .I_amp_valid(amp_valid),
    .I_column_1_amp(amp_i), .I_a11(a11_i), .I_a21(a21_i),
    .O_cos(cos_o), .O_sin(sin_o), .O_norm_valid(norm_valid_o),
    .O_div_zero(div_zero_o), .O_busy(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cos_v;
    int sin_v;
    int dz;
    int stamp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  int   last_cos = 0, last_sin = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: |a| * 2^F / amp, truncated or rounded half up, clamped to 1.0, signed.
  function automatic int ref_term(input int a, input int amp);
    longint m;
    if (amp == 0) return 0;
    m = (a < 0) ? -a : a;
`ifdef NORM_ROUND_EN
    m = ((m * (64'sd1 <<< (FRAC_W + 1))) + amp) / (2 * amp);
`else
    m = (m * (64'sd1 <<< FRAC_W)) / amp;
`endif
    if (m > (64'sd1 <<< FRAC_W)) m = 64'sd1 <<< FRAC_W;
    return (a < 0) ? -int'(m) : int'(m);
  endfunction

  // Caller positions at a negedge; strobe is sampled by the following posedge.
  task automatic send(input int a11, input int a21, input int amp, input bit accept);
    exp_t e;
    a11_i     = 16'(a11);
    a21_i     = 16'(a21);
    amp_i     = 17'(amp);
    amp_valid = 1'b1;
    if (accept) begin
      e.cos_v = ref_term(a11, amp);
      e.sin_v = ref_term(a21, amp);
      e.dz    = (amp == 0) ? 1 : 0;
      e.stamp = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    amp_valid = 1'b0;
    if (accept) check("busy_after_accept", int'(busy_o), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && norm_valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("cos", int'(cos_o), mon_e.cos_v);
        check("sin", int'(sin_o), mon_e.sin_v);
        check("div_zero", int'(div_zero_o), mon_e.dz);
        check("latency", cyc - mon_e.stamp, LAT);
        check("busy_at_pulse", int'(busy_o), 0);
        last_cos = mon_e.cos_v;
        last_sin = mon_e.sin_v;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cos", int'(cos_o), 0);
    check("rst_sin", int'(sin_o), 0);
    check("rst_valid", int'(norm_valid_o), 0);
    check("rst_div_zero", int'(div_zero_o), 0);
    check("rst_busy", int'(busy_o), 0);
    rstn = 1'b1;
    @(negedge clk);

    send(3, 4, 5, 1'b1);             drain();
    @(negedge clk); send(-3, -4, 5, 1'b1);   drain();
    @(negedge clk); send(16, 0, 16, 1'b1);   drain();
    @(negedge clk); send(2, 1, 3, 1'b1);     drain();
    @(negedge clk); send(7, -7, 0, 1'b1);    drain();
    @(negedge clk); send(9, -9, 5, 1'b1);    drain();
    @(negedge clk); send(-32768, 0, 32768, 1'b1);    drain();
    @(negedge clk); send(-32768, 32767, 1, 1'b1);    drain();
    @(negedge clk); send(32767, -1, 131071, 1'b1);   drain();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(1, 70000)), 1'b1);
      drain();
    end

    // Outputs hold their last values between pulses.
    repeat (5) @(negedge clk);
    check("hold_cos", int'(cos_o), last_cos);
    check("hold_sin", int'(sin_o), last_sin);

    // Second strobe while busy is ignored.
    @(negedge clk); send(3, 4, 5, 1'b1);
    @(negedge clk); @(negedge clk);
    send(-1000, 1000, 1001, 1'b0);
    drain();
    repeat (LAT + 4) @(negedge clk);

    // Strobe in the cycle after the pulse is accepted.
    @(negedge clk); send(2, 1, 3, 1'b1);
    for (int i = 0; i < 100 && !norm_valid_o; i++) @(negedge clk);
    check("b2b_pulse_seen", int'(norm_valid_o), 1);
    send(-5, 12, 13, 1'b1);
    drain();

    // Reset mid-division aborts at once without a pulse.
    @(negedge clk); send(1, 1, 2, 1'b0);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_cos", int'(cos_o), 0);
    check("abort_sin", int'(sin_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_valid", int'(norm_valid_o), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    send(-3, 4, 5, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
